// File: rtl/max7219_frame_loader.sv
// Loads one MAX7219 frame (13 command words) into the decoder command RAM, arms the decoder, waits for completion.
// Optional feature: define MAX7219_READBACK_EN to add a read-back verification pass that reports mismatches on o_err.
module max7219_frame_loader #(
    parameter int G_RAM_ADDR_WIDTH = 8,
    parameter int G_RAM_DATA_WIDTH = 16,
    parameter int G_BASE_ADDR      = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_start,
    input  logic [63:0]                 i_digits,
    input  logic [7:0]                  i_decode_mode,
    input  logic [3:0]                  i_intensity,
    input  logic [2:0]                  i_scan_limit,
    output logic                        o_me,
    output logic                        o_we,
    output logic [G_RAM_ADDR_WIDTH-1:0] o_addr,
    output logic [G_RAM_DATA_WIDTH-1:0] o_wdata,
    input  logic [G_RAM_DATA_WIDTH-1:0] i_rdata,
    output logic                        o_en,
    output logic [G_RAM_ADDR_WIDTH-1:0] o_start_ptr,
    output logic [G_RAM_ADDR_WIDTH-1:0] o_last_ptr,
    output logic                        o_ptr_val,
    output logic                        o_loop,
    input  logic                        i_ptr_equality,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_err
);

    localparam int AW = G_RAM_ADDR_WIDTH;
    localparam int DW = G_RAM_DATA_WIDTH;

    localparam logic [AW-1:0] BASE_ADDR    = AW'(G_BASE_ADDR);
    localparam logic [AW-1:0] LAST_ADDR    = BASE_ADDR + AW'(12);
    localparam logic [3:0]    LAST_IDX     = 4'd12;
    localparam logic [1:0]    STALE_CYCLES = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_VERIFY,
        S_CHECK,
        S_ARM,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [3:0]      n_q;
    logic [1:0]      run_cnt_q;
    logic [63:0]     digits_q;
    logic [7:0]      decode_mode_q;
    logic [3:0]      intensity_q;
    logic [2:0]      scan_limit_q;
    logic            me_q;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic            en_q;
    logic [AW-1:0]   start_ptr_q;
    logic [AW-1:0]   last_ptr_q;
    logic            ptr_val_q;
    logic            busy_q;
    logic            done_q;

    // Command word n of the frame: shutdown-exit, test off, decode, intensity, scan limit, digits 1..8.
    function automatic logic [DW-1:0] cmd_word(
        input logic [3:0]  n,
        input logic [63:0] digits,
        input logic [7:0]  decode_mode,
        input logic [3:0]  intensity,
        input logic [2:0]  scan_limit
    );
        logic [3:0]    reg_a;
        logic [7:0]    data;
        logic [2:0]    k;
        logic [DW-1:0] w;
        k = 3'(n - 4'd5);
        case (n)
            4'd0:    begin reg_a = 4'hC; data = 8'h01;                 end
            4'd1:    begin reg_a = 4'hF; data = 8'h00;                 end
            4'd2:    begin reg_a = 4'h9; data = decode_mode;           end
            4'd3:    begin reg_a = 4'hA; data = {4'h0, intensity};     end
            4'd4:    begin reg_a = 4'hB; data = {5'h00, scan_limit};   end
            default: begin reg_a = n - 4'd4; data = digits[{k, 3'b000} +: 8]; end
        endcase
        w       = '0;
        w[15:0] = {4'h0, reg_a, data};
        return w;
    endfunction

`ifdef MAX7219_READBACK_EN
    logic err_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            n_q           <= '0;
            run_cnt_q     <= '0;
            digits_q      <= '0;
            decode_mode_q <= '0;
            intensity_q   <= '0;
            scan_limit_q  <= '0;
            me_q          <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            en_q          <= 1'b0;
            start_ptr_q   <= '0;
            last_ptr_q    <= '0;
            ptr_val_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
`ifdef MAX7219_READBACK_EN
            err_q         <= 1'b0;
`endif
        end else begin
            // NOTE: strobes default low here and are raised by the one state that owns them;
            // non-blocking assignments make this later override safe within the same block.
            ptr_val_q <= 1'b0;
            done_q    <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        digits_q      <= i_digits;
                        decode_mode_q <= i_decode_mode;
                        intensity_q   <= i_intensity;
                        scan_limit_q  <= i_scan_limit;
                        busy_q        <= 1'b1;
                        me_q          <= 1'b1;
                        we_q          <= 1'b1;
                        addr_q        <= BASE_ADDR;
                        wdata_q       <= cmd_word(4'd0, i_digits, i_decode_mode, i_intensity, i_scan_limit);
                        n_q           <= '0;
                        state_q       <= S_WRITE;
`ifdef MAX7219_READBACK_EN
                        err_q         <= 1'b0;
`endif
                    end
                end

                S_WRITE: begin
                    if (n_q == LAST_IDX) begin
`ifdef MAX7219_READBACK_EN
                        we_q        <= 1'b0;
                        addr_q      <= BASE_ADDR;
                        wdata_q     <= '0;
                        n_q         <= '0;
                        state_q     <= S_VERIFY;
`else
                        me_q        <= 1'b0;
                        we_q        <= 1'b0;
                        wdata_q     <= '0;
                        start_ptr_q <= BASE_ADDR;
                        last_ptr_q  <= LAST_ADDR;
                        ptr_val_q   <= 1'b1;
                        en_q        <= 1'b1;
                        state_q     <= S_ARM;
`endif
                    end else begin
                        n_q     <= n_q + 4'd1;
                        addr_q  <= addr_q + AW'(1);
                        wdata_q <= cmd_word(n_q + 4'd1, digits_q, decode_mode_q, intensity_q, scan_limit_q);
                    end
                end

`ifdef MAX7219_READBACK_EN
                // Read data for word n-1 arrives while word n is being addressed.
                S_VERIFY: begin
                    if (n_q != 4'd0 && i_rdata != cmd_word(n_q - 4'd1, digits_q, decode_mode_q,
                                                           intensity_q, scan_limit_q)) begin
                        err_q <= 1'b1;
                    end
                    if (n_q == LAST_IDX) begin
                        me_q    <= 1'b0;
                        state_q <= S_CHECK;
                    end else begin
                        n_q    <= n_q + 4'd1;
                        addr_q <= addr_q + AW'(1);
                    end
                end

                S_CHECK: begin
                    if (i_rdata != cmd_word(LAST_IDX, digits_q, decode_mode_q, intensity_q, scan_limit_q)) begin
                        err_q <= 1'b1;
                    end
                    start_ptr_q <= BASE_ADDR;
                    last_ptr_q  <= LAST_ADDR;
                    ptr_val_q   <= 1'b1;
                    en_q        <= 1'b1;
                    state_q     <= S_ARM;
                end
`endif

                S_ARM: begin
                    run_cnt_q <= '0;
                    state_q   <= S_RUN;
                end

                // The decoder's equality flag is stale right after arming, so the first cycles are skipped.
                S_RUN: begin
                    if (run_cnt_q != STALE_CYCLES) begin
                        run_cnt_q <= run_cnt_q + 2'd1;
                    end else if (i_ptr_equality) begin
                        en_q    <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end

                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_me        = me_q;
    assign o_we        = we_q;
    assign o_addr      = addr_q;
    assign o_wdata     = wdata_q;
    assign o_en        = en_q;
    assign o_start_ptr = start_ptr_q;
    assign o_last_ptr  = last_ptr_q;
    assign o_ptr_val   = ptr_val_q;
    assign o_loop      = 1'b0;
    assign o_busy      = busy_q;
    assign o_done      = done_q;

`ifdef MAX7219_READBACK_EN
    assign o_err = err_q;
`else
    logic unused_rdata;
    assign unused_rdata = ^i_rdata;
    assign o_err        = 1'b0;
`endif

endmodule

// File: tb/tb_max7219_frame_loader.sv
// Self-checking bench for max7219_frame_loader: two instances (base 0 and base 250) share stimulus,
// each backed by a small command RAM model; a frame-level timeline model supplies every expectation.
module tb_max7219_frame_loader;

`ifdef MAX7219_READBACK_EN
    localparam bit RB    = 1'b1;
    localparam int ARM_C = 28;
`else
    localparam bit RB    = 1'b0;
    localparam int ARM_C = 14;
`endif
    localparam logic [15:0] SENTINEL = 16'hDEAD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] digits;
    logic [7:0]  dm;
    logic [3:0]  inten;
    logic [2:0]  sl;
    logic        eq;
    logic        fill_req;
    logic        corrupt;

    logic        me0, we0, en0, pv0, loop0, busy0, done0, err0;
    logic [7:0]  addr0, sp0, lp0;
    logic [15:0] wdata0, rdata0;
    logic        me1, we1, en1, pv1, loop1, busy1, done1, err1;
    logic [7:0]  addr1, sp1, lp1;
    logic [15:0] wdata1, rdata1;

    logic [15:0] mem0 [256];
    logic [15:0] mem1 [256];
    logic [15:0] exp_w [13];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    max7219_frame_loader #(.G_RAM_ADDR_WIDTH(8), .G_RAM_DATA_WIDTH(16), .G_BASE_ADDR(0)) u0 (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_digits(digits), .i_decode_mode(dm),
        .i_intensity(inten), .i_scan_limit(sl), .o_me(me0), .o_we(we0), .o_addr(addr0),
        .o_wdata(wdata0), .i_rdata(rdata0), .o_en(en0), .o_start_ptr(sp0), .o_last_ptr(lp0),
        .o_ptr_val(pv0), .o_loop(loop0), .i_ptr_equality(eq), .o_busy(busy0), .o_done(done0),
        .o_err(err0)
    );

    max7219_frame_loader #(.G_RAM_ADDR_WIDTH(8), .G_RAM_DATA_WIDTH(16), .G_BASE_ADDR(250)) u1 (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_digits(digits), .i_decode_mode(dm),
        .i_intensity(inten), .i_scan_limit(sl), .o_me(me1), .o_we(we1), .o_addr(addr1),
        .o_wdata(wdata1), .i_rdata(rdata1), .o_en(en1), .o_start_ptr(sp1), .o_last_ptr(lp1),
        .o_ptr_val(pv1), .o_loop(loop1), .i_ptr_equality(eq), .o_busy(busy1), .o_done(done1),
        .o_err(err1)
    );

    // Synchronous-read RAM models; 'corrupt' flips a bit when word 3 of the frame is read back.
    always @(posedge clk) begin
        if (fill_req) begin
            for (int i = 0; i < 256; i++) mem0[i] <= SENTINEL;
        end else if (me0 && we0) begin
            mem0[addr0] <= wdata0;
        end else if (me0) begin
            rdata0 <= mem0[addr0] ^ ((corrupt && addr0 == 8'd3) ? 16'h0100 : 16'h0000);
        end
    end

    always @(posedge clk) begin
        if (fill_req) begin
            for (int i = 0; i < 256; i++) mem1[i] <= SENTINEL;
        end else if (me1 && we1) begin
            mem1[addr1] <= wdata1;
        end else if (me1) begin
            rdata1 <= mem1[addr1] ^ ((corrupt && addr1 == 8'd253) ? 16'h0100 : 16'h0000);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference frame: register/data table straight from the MAX7219 command map.
    task automatic build_ref(input logic [63:0] f_digits, input logic [7:0] f_dm,
                             input logic [3:0] f_inten, input logic [2:0] f_sl);
        logic [7:0] regs [13];
        logic [7:0] data [13];
        regs = '{8'h0C, 8'h0F, 8'h09, 8'h0A, 8'h0B, 8'h01, 8'h02, 8'h03, 8'h04,
                 8'h05, 8'h06, 8'h07, 8'h08};
        data[0] = 8'h01;
        data[1] = 8'h00;
        data[2] = f_dm;
        data[3] = {4'h0, f_inten};
        data[4] = {5'h00, f_sl};
        for (int k = 0; k < 8; k++) data[5 + k] = f_digits[8 * k +: 8];
        for (int k = 0; k < 13; k++) exp_w[k] = {regs[k], data[k]};
    endtask

    task automatic check_zero(input string tag);
        check({tag, " u0 outputs"},
              {me0, we0, addr0, wdata0, en0, sp0, lp0, pv0, loop0, busy0, done0, err0}, 64'h0);
        check({tag, " u1 outputs"},
              {me1, we1, addr1, wdata1, en1, sp1, lp1, pv1, loop1, busy1, done1, err1}, 64'h0);
    endtask

    // Expected outputs in cycle c after the start cycle (c=0), given done cycle d.
    task automatic check_cycle(input string tag, input int c, input int d, input logic [7:0] base,
                               input logic me, input logic we, input logic [7:0] addr,
                               input logic [15:0] wdata, input logic en, input logic pv,
                               input logic loop_o, input logic busy, input logic done,
                               input logic err);
        logic        e_me, e_we, e_en, e_pv, e_busy, e_done, e_err;
        logic [7:0]  e_addr;
        logic [15:0] e_wdata;
        logic [63:0] act, exp;
        e_we    = (c >= 1 && c <= 13);
        e_me    = e_we || (RB && c >= 14 && c <= 26);
        e_addr  = 8'h00;
        e_wdata = 16'h0000;
        if (e_we) begin
            e_addr  = base + 8'(c - 1);
            e_wdata = exp_w[c - 1];
        end else if (e_me) begin
            e_addr = base + 8'(c - 14);
        end
        e_busy = (c >= 1 && c <= d);
        e_en   = (c >= ARM_C && c < d);
        e_pv   = (c == ARM_C);
        e_done = (c == d);
        e_err  = RB && corrupt && c >= 19;
        act = {busy, me, we, en, pv, done, err, loop_o, e_me ? addr : 8'h00, e_we ? wdata : 16'h0000};
        exp = {e_busy, e_me, e_we, e_en, e_pv, e_done, e_err, 1'b0, e_addr, e_wdata};
        check($sformatf("%s c%0d {busy,me,we,en,ptr_val,done,err,loop,addr,wdata}", tag, c), act, exp);
    endtask

    task automatic run_frame(input logic [63:0] f_digits, input logic [7:0] f_dm,
                             input logic [3:0] f_inten, input logic [2:0] f_sl,
                             input int eq_delay, input bit eq_always, input bit noisy,
                             input bit do_corrupt);
        int e;
        int d;
        build_ref(f_digits, f_dm, f_inten, f_sl);
        e = ARM_C + 3;
        if (!eq_always && ARM_C + eq_delay > e) e = ARM_C + eq_delay;
        d = e + 1;
        @(posedge clk); #1;
        fill_req = 1'b1;
        corrupt  = do_corrupt;
        eq       = eq_always;
        @(posedge clk); #1;
        fill_req = 1'b0;
        start    = 1'b1;
        digits   = f_digits;
        dm       = f_dm;
        inten    = f_inten;
        sl       = f_sl;
        for (int c = 1; c <= d + 1; c++) begin
            @(posedge clk); #1;
            eq = eq_always || (c >= ARM_C + eq_delay);
            if (noisy && c <= d) begin
                start  = ($urandom_range(0, 3) == 0);
                digits = {$urandom, $urandom};
                dm     = 8'($urandom);
                inten  = 4'($urandom);
                sl     = 3'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            check_cycle("u0", c, d, 8'd0, me0, we0, addr0, wdata0, en0, pv0, loop0, busy0, done0, err0);
            check_cycle("u1", c, d, 8'd250, me1, we1, addr1, wdata1, en1, pv1, loop1, busy1, done1, err1);
            if (c == ARM_C || c == d) begin
                check($sformatf("u0 c%0d {start_ptr,last_ptr}", c), {sp0, lp0}, {8'd0, 8'd12});
                check($sformatf("u1 c%0d {start_ptr,last_ptr}", c), {sp1, lp1}, {8'd250, 8'd6});
            end
        end
        start = 1'b0;
        eq    = 1'b0;
        for (int k = 0; k < 13; k++) begin
            check($sformatf("u0 ram[%0d]", k), mem0[8'(k)], exp_w[k]);
            check($sformatf("u1 ram[%0d]", (250 + k) % 256), mem1[8'(250 + k)], exp_w[k]);
        end
    endtask

    task automatic apply_reset(input logic eq_level);
        rst_n = 1'b0;
        eq    = eq_level;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [63:0] digits;
        logic [7:0]  dm;
        logic [3:0]  inten;
        logic [2:0]  sl;
        int          eq_delay;
        bit          noisy;
        logic [15:0] exp_w3;
        logic [15:0] exp_w5;
        logic [15:0] exp_w12;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{64'h0807060504030201, 8'hFF, 4'h8, 3'h7, 0, 1'b0, 16'h0A08, 16'h0101, 16'h0808};
        vecs[1] = '{64'h0000000000000000, 8'h00, 4'h0, 3'h0, 10, 1'b1, 16'h0A00, 16'h0100, 16'h0800};
        vecs[2] = '{64'hFFFFFFFFFFFFFFFF, 8'h0F, 4'hF, 3'h5, 3, 1'b0, 16'h0A0F, 16'h01FF, 16'h08FF};
        vecs[3] = '{64'h0123456789ABCDEF, 8'hA5, 4'h3, 3'h2, 6, 1'b1, 16'h0A03, 16'h01EF, 16'h0801};

        start    = 1'b0;
        digits   = '0;
        dm       = '0;
        inten    = '0;
        sl       = '0;
        eq       = 1'b0;
        fill_req = 1'b0;
        corrupt  = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_zero("power-on");
        apply_reset(1'b0);

        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i].digits, vecs[i].dm, vecs[i].inten, vecs[i].sl,
                      vecs[i].eq_delay, 1'b0, vecs[i].noisy, 1'b0);
            check($sformatf("vec%0d u0 word3", i), mem0[3], vecs[i].exp_w3);
            check($sformatf("vec%0d u0 word5", i), mem0[5], vecs[i].exp_w5);
            check($sformatf("vec%0d u1 word12", i), mem1[6], vecs[i].exp_w12);
            check($sformatf("vec%0d u1 word0", i), mem1[250], 16'h0C01);
        end

        // Equality held high from reset: done must wait out the stale window.
        apply_reset(1'b1);
        run_frame(64'h1122334455667788, 8'h0F, 4'h5, 3'h3, 0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset while word 5 is on the bus, then a full rewrite.
        @(posedge clk); #1;
        start  = 1'b1;
        digits = 64'hA1A2A3A4A5A6A7A8;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        @(negedge clk);
        check("u0 write n5 before reset {me,we,addr}", {me0, we0, addr0}, {1'b1, 1'b1, 8'd5});
        check("u1 write n5 before reset {me,we,addr}", {me1, we1, addr1}, {1'b1, 1'b1, 8'd255});
        #1 rst_n = 1'b0;
        #1;
        check_zero("mid-write reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(64'hA1A2A3A4A5A6A7A8, 8'h3C, 4'hC, 3'h6, 2, 1'b0, 1'b0, 1'b0);

        // Read-back corruption (flags o_err only with read-back built in), then a clean frame clears it.
        run_frame(64'h5555AAAA5555AAAA, 8'h81, 4'h7, 3'h1, 4, 1'b0, 1'b0, 1'b1);
        run_frame(64'h0F0E0D0C0B0A0908, 8'h42, 4'h9, 3'h4, 0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            run_frame({$urandom, $urandom}, 8'($urandom), 4'($urandom), 3'($urandom),
                      $urandom_range(0, 8), ($urandom_range(0, 3) == 0), 1'b1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
